ahb_payload_master: RTL and testbench
=====================================

Name: ahb_payload_master

Overview:
- Responder end of the I_go / I_int_* request interface that bus_translation drives.
- Accepts one payload-wide read or write request and executes it as one AHB-Lite incrementing burst of data-width beats.
- For reads, packs the returned beats into one payload word; signals completion on O_done.
- Sits between bus_translation and the SoC AHB-Lite interconnect as the boot path's only bus master.

Parameters:
- pAHB_ADDR_WIDTH, 32, HADDR / I_int_addr width.
- pAHB_DATA_WIDTH, 32, HWDATA / HRDATA width.
- pPAYLOAD_SIZE_BITS, 128, request payload width.
- Derived pBEATS = pPAYLOAD_SIZE_BITS/pAHB_DATA_WIDTH; legal values are 1, 4, 8, 16. Any other value is an elaboration error.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- I_go  in  1  request strobe; sampled only in IDLE
- I_int_addr  in  pAHB_ADDR_WIDTH  burst base byte address
- I_int_wdata  in  pPAYLOAD_SIZE_BITS  write payload
- I_int_write  in  1  1 = write, 0 = read
- O_int_rdata  out  pPAYLOAD_SIZE_BITS  assembled read payload
- O_int_rdata_valid  out  1  one-cycle pulse, read completed without error
- O_done  out  1  one-cycle pulse, request finished (success or error)
- O_err  out  1  error flag, valid with O_done
- O_busy  out  1  high from request acceptance through the O_done cycle
- HADDR  out  pAHB_ADDR_WIDTH  AHB address
- HTRANS  out  2  IDLE=00, NONSEQ=10, SEQ=11
- HWRITE  out  1  AHB direction
- HSIZE  out  3  log2(pAHB_DATA_WIDTH/8)
- HBURST  out  3  SINGLE=000 / INCR4=011 / INCR8=101 / INCR16=111, chosen by pBEATS
- HWDATA  out  pAHB_DATA_WIDTH  write data
- HRDATA  in  pAHB_DATA_WIDTH  read data
- HREADY  in  1  transfer ready
- HRESP  in  1  0 = OKAY, 1 = ERROR

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-high, rst.
- Reset values (all outputs registered):
  - all outputs 0, including HTRANS=IDLE and O_int_rdata=0;
  - HSIZE and HBURST are the only exceptions: they are constants and are not reset.
- Request capture (IDLE and I_go=1):
  - latch address with bits [log2(pPAYLOAD_SIZE_BITS/8)-1:0] forced to 0, so bursts are payload-aligned and never cross 1 KB;
  - latch wdata and write; set O_busy.
  - I_go while busy is ignored and never queued.
- States: IDLE, ADDR, BURST, LAST, DONE.
  - IDLE: HTRANS=IDLE. Go to ADDR when I_go=1.
  - ADDR: drive HTRANS=NONSEQ, HADDR=base, HWRITE. On HREADY, move to BURST, or to LAST if pBEATS=1.
  - BURST: drive HTRANS=SEQ, HADDR=base+k*(pAHB_DATA_WIDTH/8) for beat k.
    - Each HREADY advances k and completes the previous beat's data phase.
    - After the address of beat pBEATS-1 is accepted, go to LAST.
  - LAST: HTRANS=IDLE, final data phase outstanding. On HREADY, go to DONE.
  - DONE: pulse O_done for one cycle (plus O_int_rdata_valid for reads); clear O_busy; go to IDLE.
- All AHB outputs hold stable while HREADY=0.
- Beat mapping:
  - write beat k drives HWDATA = wdata[k*W+:W] during beat k's data phase (W = pAHB_DATA_WIDTH);
  - read beat k stores HRDATA into O_int_rdata[k*W+:W] on the HREADY of beat k's data phase (sub-module).
- O_int_rdata holds its value until the next successful read. Write requests and failed reads do not modify it.
- Latency with HREADY stuck at 1 and pBEATS=4:
  - I_go sampled in cycle 0; NONSEQ in cycle 1; SEQ in cycles 2-4; final data phase in cycle 5; O_done in cycle 6.
  - Total 2+pBEATS cycles from I_go to O_done.
- Error handling (HRESP=1 with HREADY=0, first cycle of the two-cycle ERROR response):
  - drive HTRANS=IDLE in that same cycle, cancelling any pipelined address;
  - wait for HREADY=1 and go to DONE with O_err=1;
  - O_int_rdata_valid stays 0 and O_int_rdata is unchanged.
- Asynchronous reset mid-burst returns to IDLE immediately with all outputs at reset values. No completion pulse is issued for the aborted request.

Decomposition:
- Package ahb_master_pkg:
  - htrans_t and hburst_t encodings;
  - the state_t enum;
  - a function mapping pBEATS to an HBURST encoding.
- Sub-module ahb_rdata_packer: beat-indexed register file writing W-bit slices into the payload register, with commit/discard on completion.

Test Plan:
1. Write 0x00112233_44556677_8899AABB_CCDDEEFF to 0x2000_0010, HREADY=1 -> addresses 0x10, 0x14, 0x18, 0x1C with HTRANS NONSEQ,SEQ,SEQ,SEQ; HWDATA 0xCCDDEEFF, 0x8899AABB, 0x44556677, 0x00112233; O_done in cycle 6, O_err=0.
2. Read 0x2000_0000, slave returns 0xA0, 0xA1, 0xA2, 0xA3 -> O_int_rdata=0x000000A3_000000A2_000000A1_000000A0; rdata_valid and O_done in the same cycle.
3. Read with 2 wait states on beat 2 -> HADDR/HTRANS stable during waits; O_done in cycle 8; correct data.
4. ERROR response on write beat 1 -> HTRANS=IDLE in the first error cycle; no further beats; O_done=1, O_err=1. A following read still succeeds.
5. I_go pulses during a busy read, then rst asserted mid-burst -> the extra I_go is ignored; after reset all outputs are 0 and HTRANS=IDLE. A new request after reset completes normally.
6. Address 0x2000_000C -> burst starts at 0x2000_0000.

Source files
------------

// File: rtl/ahb_payload_master_pkg.sv
// Shared encodings and helpers for the payload-wide AHB-Lite burst master.
package ahb_master_pkg;

  typedef enum logic [1:0] {
    HtIdle   = 2'b00,
    HtBusy   = 2'b01,
    HtNonseq = 2'b10,
    HtSeq    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HbSingle = 3'b000,
    HbIncr   = 3'b001,
    HbIncr4  = 3'b011,
    HbIncr8  = 3'b101,
    HbIncr16 = 3'b111
  } hburst_t;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StBurst,
    StLast,
    StDone
  } state_t;

  function automatic hburst_t hburst_for(int unsigned beats);
    case (beats)
      4:       return HbIncr4;
      8:       return HbIncr8;
      16:      return HbIncr16;
      default: return HbSingle;
    endcase
  endfunction

endpackage

// File: rtl/ahb_payload_master_if.sv
// AHB-Lite master/slave signal bundle used by the payload master.
interface ahb_payload_master_if #(
  parameter int unsigned pAHB_ADDR_WIDTH = 32,
  parameter int unsigned pAHB_DATA_WIDTH = 32
);
  logic [pAHB_ADDR_WIDTH-1:0] HADDR;
  logic [1:0]                 HTRANS;
  logic                       HWRITE;
  logic [2:0]                 HSIZE;
  logic [2:0]                 HBURST;
  logic [pAHB_DATA_WIDTH-1:0] HWDATA;
  logic [pAHB_DATA_WIDTH-1:0] HRDATA;
  logic                       HREADY;
  logic                       HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_rdata_packer.sv
// Collects read beats into a staging payload; the visible payload only changes on commit.
module ahb_rdata_packer #(
  parameter int unsigned DataW    = 32,
  parameter int unsigned PayloadW = 128,
  parameter int unsigned IdxW     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IdxW-1:0]     idx,
  input  logic [DataW-1:0]    wdata,
  input  logic                commit,
  output logic [PayloadW-1:0] rdata
);
  logic [PayloadW-1:0] stage_q, merged, rdata_q;

  // Final beat is merged in the same cycle it commits.
  always_comb begin
    merged = stage_q;
    if (wr_en) merged[idx * DataW +: DataW] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
      rdata_q <= '0;
    end else begin
      stage_q <= merged;
      if (commit) rdata_q <= merged;
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/ahb_payload_master.sv
// Executes one payload-wide read or write as a single AHB-Lite incrementing burst.
module ahb_payload_master
  import ahb_master_pkg::*;
#(
  parameter int unsigned pAHB_ADDR_WIDTH    = 32,
  parameter int unsigned pAHB_DATA_WIDTH    = 32,
  parameter int unsigned pPAYLOAD_SIZE_BITS = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          I_go,
  input  logic [pAHB_ADDR_WIDTH-1:0]    I_int_addr,
  input  logic [pPAYLOAD_SIZE_BITS-1:0] I_int_wdata,
  input  logic                          I_int_write,
  output logic [pPAYLOAD_SIZE_BITS-1:0] O_int_rdata,
  output logic                          O_int_rdata_valid,
  output logic                          O_done,
  output logic                          O_err,
  output logic                          O_busy,
  ahb_payload_master_if.master          ahb
);
  localparam int unsigned NumBeats     = pPAYLOAD_SIZE_BITS / pAHB_DATA_WIDTH;
  localparam int unsigned BeatBytes    = pAHB_DATA_WIDTH / 8;
  localparam int unsigned PayloadBytes = pPAYLOAD_SIZE_BITS / 8;
  localparam int unsigned BeatW        = (NumBeats > 1) ? $clog2(NumBeats) : 1;

  typedef logic [pAHB_ADDR_WIDTH-1:0] addr_t;
  typedef logic [BeatW-1:0]           beat_t;

  if (NumBeats != 1 && NumBeats != 4 && NumBeats != 8 && NumBeats != 16) begin : g_bad_beats
    $error("ahb_payload_master: payload/data width ratio must be 1, 4, 8 or 16");
  end

  state_t                        state_q, state_d;
  beat_t                         beat_q, beat_d;
  addr_t                         base_q, base_d, haddr_q, haddr_d;
  logic [pPAYLOAD_SIZE_BITS-1:0] wdata_q, wdata_d;
  logic [pAHB_DATA_WIDTH-1:0]    hwdata_q, hwdata_d;
  htrans_t                       htrans_q, htrans_d;
  logic write_q, write_d, err_q, err_d, hwrite_q, hwrite_d;
  logic done_q, done_d, err_out_q, err_out_d, valid_q, valid_d, busy_q, busy_d;
  logic pk_wr, pk_commit;
  beat_t pk_idx;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    err_d     = err_q;
    haddr_d   = haddr_q;
    htrans_d  = htrans_q;
    hwrite_d  = hwrite_q;
    hwdata_d  = hwdata_q;
    done_d    = 1'b0;
    err_out_d = 1'b0;
    valid_d   = 1'b0;
    pk_wr     = 1'b0;
    pk_idx    = beat_q - beat_t'(1);
    pk_commit = 1'b0;
    unique case (state_q)
      StIdle: begin
        htrans_d = HtIdle;
        if (I_go) begin
          base_d   = I_int_addr & ~addr_t'(PayloadBytes - 1);
          wdata_d  = I_int_wdata;
          write_d  = I_int_write;
          err_d    = 1'b0;
          beat_d   = '0;
          haddr_d  = base_d;
          htrans_d = HtNonseq;
          hwrite_d = I_int_write;
          state_d  = StAddr;
        end
      end
      StAddr: begin
        if (ahb.HREADY) begin
          hwdata_d = wdata_q[beat_q * pAHB_DATA_WIDTH +: pAHB_DATA_WIDTH];
          if (NumBeats == 1) begin
            htrans_d = HtIdle;
            state_d  = StLast;
          end else begin
            beat_d   = beat_q + beat_t'(1);
            haddr_d  = base_q + addr_t'(BeatBytes);
            htrans_d = HtSeq;
            state_d  = StBurst;
          end
        end
      end
      StBurst: begin
        if (ahb.HRESP && !ahb.HREADY) begin
          htrans_d = HtIdle;
          err_d    = 1'b1;
          state_d  = StLast;
        end else if (ahb.HREADY) begin
          pk_wr    = !write_q;
          hwdata_d = wdata_q[beat_q * pAHB_DATA_WIDTH +: pAHB_DATA_WIDTH];
          if (beat_q == beat_t'(NumBeats - 1)) begin
            htrans_d = HtIdle;
            state_d  = StLast;
          end else begin
            beat_d  = beat_q + beat_t'(1);
            haddr_d = base_q + addr_t'(beat_d) * addr_t'(BeatBytes);
          end
        end
      end
      StLast: begin
        if (ahb.HRESP && !ahb.HREADY) begin
          err_d = 1'b1;
        end else if (ahb.HREADY) begin
          state_d   = StDone;
          done_d    = 1'b1;
          err_out_d = err_q || ahb.HRESP;
          if (!err_q && !ahb.HRESP && !write_q) begin
            pk_wr     = 1'b1;
            pk_idx    = beat_t'(NumBeats - 1);
            pk_commit = 1'b1;
            valid_d   = 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      beat_q    <= '0;
      base_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      haddr_q   <= '0;
      htrans_q  <= HtIdle;
      hwrite_q  <= 1'b0;
      hwdata_q  <= '0;
      done_q    <= 1'b0;
      err_out_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      err_q     <= err_d;
      haddr_q   <= haddr_d;
      htrans_q  <= htrans_d;
      hwrite_q  <= hwrite_d;
      hwdata_q  <= hwdata_d;
      done_q    <= done_d;
      err_out_q <= err_out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  ahb_rdata_packer #(
    .DataW    (pAHB_DATA_WIDTH),
    .PayloadW (pPAYLOAD_SIZE_BITS),
    .IdxW     (BeatW)
  ) u_packer (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (pk_wr),
    .idx    (pk_idx),
    .wdata  (ahb.HRDATA),
    .commit (pk_commit),
    .rdata  (O_int_rdata)
  );

  // First ERROR cycle must cancel the pipelined SEQ address before the next edge.
  assign ahb.HTRANS = (state_q == StBurst && ahb.HRESP && !ahb.HREADY) ? HtIdle : htrans_q;
  assign ahb.HADDR  = haddr_q;
  assign ahb.HWRITE = hwrite_q;
  assign ahb.HWDATA = hwdata_q;
  assign ahb.HSIZE  = 3'($clog2(BeatBytes));
  assign ahb.HBURST = hburst_for(NumBeats);

  assign O_done            = done_q;
  assign O_err             = err_out_q;
  assign O_int_rdata_valid = valid_q;
  assign O_busy            = busy_q;
endmodule

// File: tb/tb_ahb_payload_master.sv
// Directed bench for ahb_payload_master with hand-computed expectations (32-bit bus, 128-bit payload).
module tb_ahb_payload_master;
  logic         clk = 1'b0;
  logic         rst;
  logic         I_go;
  logic [31:0]  I_int_addr;
  logic [127:0] I_int_wdata;
  logic         I_int_write;
  logic [127:0] O_int_rdata;
  logic         O_int_rdata_valid, O_done, O_err, O_busy;
  int           total = 0;
  int           bad = 0;
  logic [127:0] wd;
  logic [127:0] last_rd;

  always #5 clk = ~clk;

  ahb_payload_master_if #(.pAHB_ADDR_WIDTH(32), .pAHB_DATA_WIDTH(32)) bus ();

  ahb_payload_master #(
    .pAHB_ADDR_WIDTH    (32),
    .pAHB_DATA_WIDTH    (32),
    .pPAYLOAD_SIZE_BITS (128)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .I_go              (I_go),
    .I_int_addr        (I_int_addr),
    .I_int_wdata       (I_int_wdata),
    .I_int_write       (I_int_write),
    .O_int_rdata       (O_int_rdata),
    .O_int_rdata_valid (O_int_rdata_valid),
    .O_done            (O_done),
    .O_err             (O_err),
    .O_busy            (O_busy),
    .ahb               (bus)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Called at a falling edge; request is sampled on the next rising edge (cycle 0).
  task automatic read_burst(input logic [31:0] addr, input logic [31:0] exp_base,
                            input logic [31:0] d0);
    logic [127:0] exp;
    exp = {d0 + 32'd3, d0 + 32'd2, d0 + 32'd1, d0};
    I_go = 1'b1; I_int_addr = addr; I_int_write = 1'b0; I_int_wdata = '0;
    @(negedge clk);
    I_go = 1'b0;
    chk("rd_nonseq", bus.HTRANS, 2'b10);
    chk("rd_base", bus.HADDR, exp_base);
    chk("rd_hwrite", bus.HWRITE, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.HRDATA = d0 + 32'(k);
    end
    @(negedge clk);
    chk("rd_done", O_done, 1'b1);
    chk("rd_valid", O_int_rdata_valid, 1'b1);
    chk("rd_err", O_err, 1'b0);
    chk("rd_data", O_int_rdata, exp);
    @(negedge clk);
    bus.HRDATA = '0;
    chk("rd_done_clr", O_done, 1'b0);
    chk("rd_busy_clr", O_busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; I_go = 1'b0; I_int_addr = '0; I_int_wdata = '0; I_int_write = 1'b0;
    bus.HRDATA = '0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_htrans", bus.HTRANS, 2'b00);
    chk("rst_haddr", bus.HADDR, 32'h0);
    chk("rst_busy", O_busy, 1'b0);
    chk("rst_done", O_done, 1'b0);
    chk("rst_rdata", O_int_rdata, 128'h0);
    chk("hsize", bus.HSIZE, 3'b010);
    chk("hburst", bus.HBURST, 3'b011);
    rst = 1'b0;
    @(negedge clk);

    // 1: four-beat write, zero wait states
    wd = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    I_go = 1'b1; I_int_addr = 32'h2000_0010; I_int_write = 1'b1; I_int_wdata = wd;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      I_go = 1'b0;
      chk("wr_htrans", bus.HTRANS, (k == 0) ? 2'b10 : 2'b11);
      chk("wr_haddr", bus.HADDR, 32'h2000_0010 + 32'(4 * k));
      chk("wr_hwrite", bus.HWRITE, 1'b1);
      chk("wr_busy", O_busy, 1'b1);
      if (k > 0) chk("wr_hwdata", bus.HWDATA, wd[(k - 1) * 32 +: 32]);
    end
    @(negedge clk);
    chk("wr_last_idle", bus.HTRANS, 2'b00);
    chk("wr_last_data", bus.HWDATA, 32'h0011_2233);
    chk("wr_no_early_done", O_done, 1'b0);
    @(negedge clk);
    chk("wr_done", O_done, 1'b1);
    chk("wr_err", O_err, 1'b0);
    chk("wr_novalid", O_int_rdata_valid, 1'b0);
    chk("wr_busy_done", O_busy, 1'b1);
    chk("wr_rdata_kept", O_int_rdata, 128'h0);
    @(negedge clk);
    chk("wr_done_clr", O_done, 1'b0);
    chk("wr_busy_clr", O_busy, 1'b0);

    // 2: four-beat read
    read_burst(32'h2000_0000, 32'h2000_0000, 32'hA0);

    // 3: read with two wait states on beat 2
    I_go = 1'b1; I_int_addr = 32'h2000_0040; I_int_write = 1'b0;
    @(negedge clk);
    I_go = 1'b0;
    @(negedge clk); bus.HRDATA = 32'hB0;
    @(negedge clk); bus.HRDATA = 32'hB1;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      bus.HREADY = (w == 2);
      bus.HRDATA = (w == 2) ? 32'hB2 : 32'hDEAD_BEEF;
      chk("ws_haddr", bus.HADDR, 32'h2000_004C);
      chk("ws_htrans", bus.HTRANS, 2'b11);
    end
    @(negedge clk); bus.HRDATA = 32'hB3;
    chk("ws_last_idle", bus.HTRANS, 2'b00);
    chk("ws_no_early_done", O_done, 1'b0);
    @(negedge clk);
    chk("ws_done", O_done, 1'b1);
    chk("ws_valid", O_int_rdata_valid, 1'b1);
    chk("ws_data", O_int_rdata, 128'h000000B3_000000B2_000000B1_000000B0);
    last_rd = 128'h000000B3_000000B2_000000B1_000000B0;
    @(negedge clk);

    // 4: ERROR on write beat 1
    I_go = 1'b1; I_int_addr = 32'h2000_0100; I_int_write = 1'b1;
    I_int_wdata = 128'h44444444_33333333_22222222_11111111;
    @(negedge clk);
    I_go = 1'b0;
    @(negedge clk);
    chk("er_beat0_data", bus.HWDATA, 32'h1111_1111);
    @(negedge clk);
    bus.HREADY = 1'b0; bus.HRESP = 1'b1;
    #1;
    chk("er_cancel", bus.HTRANS, 2'b00);
    chk("er_haddr_hold", bus.HADDR, 32'h2000_0108);
    @(negedge clk);
    bus.HREADY = 1'b1;
    chk("er_idle2", bus.HTRANS, 2'b00);
    chk("er_no_early_done", O_done, 1'b0);
    @(negedge clk);
    bus.HRESP = 1'b0;
    chk("er_done", O_done, 1'b1);
    chk("er_err", O_err, 1'b1);
    chk("er_novalid", O_int_rdata_valid, 1'b0);
    chk("er_rdata_kept", O_int_rdata, last_rd);
    @(negedge clk);
    chk("er_idle_after", bus.HTRANS, 2'b00);
    chk("er_busy_clr", O_busy, 1'b0);
    read_burst(32'h2000_0200, 32'h2000_0200, 32'hC0);

    // 5: I_go while busy is ignored
    I_go = 1'b1; I_int_addr = 32'h2000_0300; I_int_write = 1'b0;
    @(negedge clk);
    I_int_addr = 32'h3000_0000; I_int_write = 1'b1;
    @(negedge clk);
    I_go = 1'b0; bus.HRDATA = 32'hD0;
    chk("bz_htrans", bus.HTRANS, 2'b11);
    chk("bz_haddr", bus.HADDR, 32'h2000_0304);
    chk("bz_hwrite", bus.HWRITE, 1'b0);
    @(negedge clk); bus.HRDATA = 32'hD1;
    @(negedge clk); bus.HRDATA = 32'hD2;
    @(negedge clk); bus.HRDATA = 32'hD3;
    @(negedge clk);
    chk("bz_done", O_done, 1'b1);
    chk("bz_data", O_int_rdata, 128'h000000D3_000000D2_000000D1_000000D0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("bz_not_queued", bus.HTRANS, 2'b00);
      chk("bz_idle_busy", O_busy, 1'b0);
    end

    // 5b: reset mid-burst
    I_go = 1'b1; I_int_addr = 32'h2000_0400; I_int_write = 1'b0;
    @(negedge clk);
    I_go = 1'b0;
    @(negedge clk); bus.HRDATA = 32'hE0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ar_htrans", bus.HTRANS, 2'b00);
    chk("ar_haddr", bus.HADDR, 32'h0);
    chk("ar_hwrite", bus.HWRITE, 1'b0);
    chk("ar_hwdata", bus.HWDATA, 32'h0);
    chk("ar_busy", O_busy, 1'b0);
    chk("ar_done", O_done, 1'b0);
    chk("ar_rdata", O_int_rdata, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ar_no_done", O_done, 1'b0);
      chk("ar_stay_idle", bus.HTRANS, 2'b00);
    end
    read_burst(32'h2000_0500, 32'h2000_0500, 32'h50);

    // 6: unaligned address is payload-aligned
    read_burst(32'h2000_000C, 32'h2000_0000, 32'h60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
